trap_csr_unit: RTL and testbench

- Machine-mode trap responder in the RISCV_Core; consumes `trap_entry_en`, `int_index` and `trap_exit_en` from the interrupt controller.
- Holds `mstatus`, `mtvec`, `mepc` and `mcause`; returns the `mstatus.MIE` bit to the controller as `int_mstatus_mie`.
- Latches single-cycle interrupt requests and takes them at the next instruction-retire boundary.
- On entry: redirects the fetch PC to the handler and updates the CSRs. On mret: redirects back to `mepc` and restores MIE.

---
 rtl/trap_csr_unit.sv | 103 ++++++++++
 tb/tb_trap_csr_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine-mode trap entry/mret sequencer holding mstatus, mtvec, mepc and mcause.
// Optional macro TRAP_VECTORED_EN: makes mtvec[1:0] writable and enables vectored handler addressing (MODE=2'b01).
module trap_csr_unit #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            trap_entry_en,
   input  logic [3:0]      int_index,
   input  logic            trap_exit_en,
   input  logic            instr_retire,
   input  logic [XLEN-1:0] retire_next_pc,
   input  logic            csr_we,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            int_mstatus_mie,
   output logic            pc_redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            pipe_flush
);
   typedef enum logic [1:0] {IDLE, ENTER, HANDLER, EXIT} state_t;
   state_t          state;
   logic            mie, mpie, pending, take;
   logic [3:0]      pend_cause;
   logic [XLEN-1:0] mtvec, mepc, mcause, mtvec_w, mtvec_rst, handler, base;
   logic            wr_mstatus, wr_mtvec, wr_mepc, wr_mcause;
   assign take = pending & mie & instr_retire & ~trap_exit_en & (state == IDLE);
   assign wr_mstatus = csr_we & (csr_addr == 12'h300);
   assign wr_mtvec = csr_we & (csr_addr == 12'h305);
   assign wr_mepc = csr_we & (csr_addr == 12'h341);
   assign wr_mcause = csr_we & (csr_addr == 12'h342);
   assign base = mtvec & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
   assign mtvec_w = csr_wdata;
   assign mtvec_rst = MTVEC_RESET;
   assign handler = (mtvec[1:0] == 2'b01) ? base + {{(XLEN-6){1'b0}}, pend_cause, 2'b00} : base;
`else
   assign mtvec_w = csr_wdata & ~XLEN'(3);
   assign mtvec_rst = MTVEC_RESET & ~XLEN'(3);
   assign handler = base;
`endif
   assign int_mstatus_mie = mie;
   assign pipe_flush = pc_redirect;
   // combinational CSR read port, unmapped addresses read zero
   always_comb
      csr_rdata = (csr_addr == 12'h300) ? {{(XLEN-8){1'b0}}, mpie, 3'b000, mie, 3'b000} :
                  (csr_addr == 12'h305) ? mtvec :
                  (csr_addr == 12'h341) ? mepc :
                  (csr_addr == 12'h342) ? mcause : '0;
   // CSR state and pending latch; hardware trap updates override software writes
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mie <= 1'b0;
         mpie <= 1'b0;
         mtvec <= mtvec_rst;
         mepc <= '0;
         mcause <= '0;
         pending <= 1'b0;
         pend_cause <= 4'h0;
      end else begin
         if (trap_exit_en) begin
            mie <= mpie;
            mpie <= 1'b1;
         end else if (take) begin
            mpie <= mie;
            mie <= 1'b0;
         end else if (wr_mstatus) begin
            mie <= csr_wdata[3];
            mpie <= csr_wdata[7];
         end
         if (wr_mtvec) mtvec <= mtvec_w;
         if (take) begin
            mepc <= retire_next_pc & ~XLEN'(3);
            mcause <= {1'b1, {(XLEN-5){1'b0}}, pend_cause};
         end else begin
            if (wr_mepc) mepc <= csr_wdata & ~XLEN'(3);
            if (wr_mcause) mcause <= csr_wdata;
         end
         pending <= take ? 1'b0 : (pending | trap_entry_en);
         if (!pending && trap_entry_en) pend_cause <= int_index;
      end
   // trap sequencer with registered one-cycle redirect strobe; mret has priority over a take
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         pc_redirect <= 1'b0;
         redirect_pc <= '0;
      end else begin
         pc_redirect <= 1'b0;
         if (trap_exit_en) begin
            state <= EXIT;
            pc_redirect <= 1'b1;
            redirect_pc <= mepc;
         end else if (take) begin
            state <= ENTER;
            pc_redirect <= 1'b1;
            redirect_pc <= handler;
         end else
            state <= (state == ENTER) ? HANDLER : (state == EXIT) ? IDLE : state;
      end
endmodule

// File: tb/tb_trap_csr_unit.sv
// tb_trap_csr_unit: directed stimulus with a word-level reference model and per-cycle output comparison.
module tb_trap_csr_unit;
`ifdef TRAP_VECTORED_EN
   localparam bit VEC = 1'b1;
`else
   localparam bit VEC = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trap_entry_en = 1'b0;
   logic [3:0]  int_index = 4'h0;
   logic        trap_exit_en = 1'b0;
   logic        instr_retire = 1'b0;
   logic [31:0] retire_next_pc = 32'h0;
   logic        csr_we = 1'b0;
   logic [11:0] csr_addr = 12'h0;
   logic [31:0] csr_wdata = 32'h0;
   logic [31:0] csr_rdata, redirect_pc;
   logic        int_mstatus_mie, pc_redirect, pipe_flush;
   int          checks = 0;
   int          errors = 0;

   trap_csr_unit dut (
      .clk(clk), .rst_n(rst_n), .trap_entry_en(trap_entry_en), .int_index(int_index),
      .trap_exit_en(trap_exit_en), .instr_retire(instr_retire), .retire_next_pc(retire_next_pc),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .int_mstatus_mie(int_mstatus_mie), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
      .pipe_flush(pipe_flush)
   );

   always #5 clk = ~clk;

   // reference model: CSRs as whole words, "in handler" flag, expected redirect
   logic [31:0] m_st, m_tvec, m_epc, m_cause, m_pc;
   logic [3:0]  m_pcause;
   logic        m_pend, m_busy, m_redir, take_m;
   assign take_m = m_pend && m_st[3] && instr_retire && !trap_exit_en && !m_busy && !m_redir;

   function automatic logic [31:0] m_handler();
      return (m_tvec & ~32'h3) + ((VEC && m_tvec[1:0] == 2'b01) ? {24'h0, m_pcause, 4'h0} >> 2 : 32'h0);
   endfunction

   function automatic logic [31:0] m_rd(input logic [11:0] a);
      return a == 12'h300 ? m_st : a == 12'h305 ? m_tvec : a == 12'h341 ? m_epc : a == 12'h342 ? m_cause : 32'h0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= 32'h0; m_tvec <= 32'h100; m_epc <= 32'h0; m_cause <= 32'h0;
         m_pend <= 1'b0; m_pcause <= 4'h0; m_busy <= 1'b0; m_redir <= 1'b0; m_pc <= 32'h0;
      end else begin
         m_redir <= trap_exit_en || take_m;
         if (trap_exit_en) begin
            m_st <= 32'h80 | (m_st[7] ? 32'h8 : 32'h0);
            m_pc <= m_epc;
            m_busy <= 1'b0;
         end else if (take_m) begin
            m_st <= 32'h80;
            m_pc <= m_handler();
            m_busy <= 1'b1;
         end else if (csr_we && csr_addr == 12'h300)
            m_st <= csr_wdata & 32'h88;
         if (take_m) begin
            m_epc <= retire_next_pc & ~32'h3;
            m_cause <= 32'h8000_0000 + 32'(m_pcause);
         end else begin
            if (csr_we && csr_addr == 12'h341) m_epc <= csr_wdata & ~32'h3;
            if (csr_we && csr_addr == 12'h342) m_cause <= csr_wdata;
         end
         if (csr_we && csr_addr == 12'h305) m_tvec <= VEC ? csr_wdata : (csr_wdata & ~32'h3);
         if (take_m) m_pend <= 1'b0;
         else if (!m_pend && trap_entry_en) begin
            m_pend <= 1'b1;
            m_pcause <= int_index;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk)
      if (rst_n) begin
         chk("cyc_pc_redirect", 32'(pc_redirect), 32'(m_redir));
         chk("cyc_pipe_flush", 32'(pipe_flush), 32'(m_redir));
         chk("cyc_mie", 32'(int_mstatus_mie), 32'(m_st[3]));
         chk("cyc_rdata", csr_rdata, m_rd(csr_addr));
         if (m_redir) chk("cyc_redirect_pc", redirect_pc, m_pc);
      end

   task automatic cyc(input logic te, input logic [3:0] idx, input logic tx, input logic ret,
                      input logic [31:0] npc, input logic we, input logic [11:0] a, input logic [31:0] wd);
      trap_entry_en = te; int_index = idx; trap_exit_en = tx; instr_retire = ret;
      retire_next_pc = npc; csr_we = we; csr_addr = a; csr_wdata = wd;
      @(posedge clk);
      #1;
      trap_entry_en = 1'b0; trap_exit_en = 1'b0; instr_retire = 1'b0; csr_we = 1'b0;
   endtask

   task automatic idle();
      cyc(0, 4'h0, 0, 0, 32'h0, 0, csr_addr, 32'h0);
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
      csr_addr = a;
      #1;
      chk(nm, csr_rdata, exp);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      rd(12'h305, 32'h100, "rst_mtvec");
      rd(12'h300, 32'h0, "rst_mstatus");
      chk("rst_mie", 32'(int_mstatus_mie), 32'h0);
      chk("rst_redirect", 32'(pc_redirect), 32'h0);
      // first trap: cause F at retire of next_pc 0x2000
      cyc(0, 4'h0, 0, 0, 32'h0, 1, 12'h300, 32'h8);
      rd(12'h300, 32'h8, "mstatus_wr");
      cyc(1, 4'hF, 0, 0, 32'h0, 0, 12'h300, 32'h0);
      cyc(0, 4'h0, 0, 1, 32'h2000, 0, 12'h300, 32'h0);
      chk("entry_redirect", 32'(pc_redirect), 32'h1);
      chk("entry_pc", redirect_pc, 32'h100);
      rd(12'h341, 32'h2000, "entry_mepc");
      rd(12'h342, 32'h8000_000F, "entry_mcause");
      rd(12'h300, 32'h80, "entry_mstatus");
      idle();
      chk("handler_no_redirect", 32'(pc_redirect), 32'h0);
      // mret from handler
      cyc(0, 4'h0, 1, 0, 32'h0, 0, 12'h300, 32'h0);
      chk("exit_redirect", 32'(pc_redirect), 32'h1);
      chk("exit_pc", redirect_pc, 32'h2000);
      rd(12'h300, 32'h88, "exit_mstatus");
      idle();
      // first request wins
      cyc(1, 4'hC, 0, 0, 32'h0, 0, 12'h300, 32'h0);
      cyc(1, 4'h8, 0, 0, 32'h0, 0, 12'h300, 32'h0);
      cyc(0, 4'h0, 0, 1, 32'h4000, 0, 12'h300, 32'h0);
      chk("first_wins_redirect", 32'(pc_redirect), 32'h1);
      rd(12'h342, 32'h8000_000C, "first_wins_cause");
      idle();
      cyc(0, 4'h0, 1, 0, 32'h0, 0, 12'h300, 32'h0);
      chk("exit2_pc", redirect_pc, 32'h4000);
      idle();
      cyc(0, 4'h0, 0, 1, 32'h4100, 0, 12'h300, 32'h0);
      chk("dropped_not_taken", 32'(pc_redirect), 32'h0);
      // vectored mtvec and software mepc write colliding with the take
      cyc(0, 4'h0, 0, 0, 32'h0, 1, 12'h305, 32'h101);
      rd(12'h305, VEC ? 32'h101 : 32'h100, "mtvec_mode");
      cyc(1, 4'h4, 0, 0, 32'h0, 0, 12'h305, 32'h0);
      cyc(0, 4'h0, 0, 1, 32'h5004, 1, 12'h341, 32'h3000);
      chk("vec_redirect", 32'(pc_redirect), 32'h1);
      chk("vec_pc", redirect_pc, VEC ? 32'h110 : 32'h100);
      rd(12'h341, 32'h5004, "hw_beats_sw_mepc");
      // reset during ENTER aborts the redirect at once
      rst_n = 1'b0;
      #1;
      chk("abort_redirect", 32'(pc_redirect), 32'h0);
      chk("abort_flush", 32'(pipe_flush), 32'h0);
      rd(12'h305, 32'h100, "abort_mtvec");
      rd(12'h341, 32'h0, "abort_mepc");
      rd(12'h342, 32'h0, "abort_mcause");
      rd(12'h300, 32'h0, "abort_mstatus");
      #1 rst_n = 1'b1;
      idle();
      // mret coinciding with the take condition
      cyc(0, 4'h0, 0, 0, 32'h0, 1, 12'h300, 32'h8);
      cyc(1, 4'h3, 0, 0, 32'h0, 0, 12'h300, 32'h0);
      cyc(0, 4'h0, 1, 1, 32'h7000, 0, 12'h300, 32'h0);
      chk("mret_wins_pc", redirect_pc, 32'h0);
      rd(12'h300, 32'h80, "mret_wins_mstatus");
      idle();
      cyc(0, 4'h0, 0, 1, 32'h6000, 0, 12'h300, 32'h0);
      chk("mie0_no_take", 32'(pc_redirect), 32'h0);
      cyc(0, 4'h0, 0, 0, 32'h0, 1, 12'h300, 32'h8);
      cyc(0, 4'h0, 0, 1, 32'h6000, 1, 12'h300, 32'h0);
      chk("late_take_redirect", 32'(pc_redirect), 32'h1);
      rd(12'h342, 32'h8000_0003, "late_take_cause");
      rd(12'h300, 32'h80, "hw_beats_sw_mstatus");
      // write masks and unmapped reads
      cyc(0, 4'h0, 0, 0, 32'h0, 1, 12'h341, 32'h3003);
      rd(12'h341, 32'h3000, "mepc_align");
      cyc(0, 4'h0, 0, 0, 32'h0, 1, 12'h300, 32'hFFFF_FFFF);
      rd(12'h300, 32'h88, "mstatus_mask");
      rd(12'h123, 32'h0, "unmapped");
      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
